regbus_cmd_master: RTL and testbench

REGBUS_CMD_MASTER -- requirements
Module: regbus_cmd_master

---
 rtl/regbus_cmd_master.sv | 262 ++++++++++++++++++++++++++
 tb/tb_regbus_cmd_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbus_cmd_master.sv
// Byte-stream command master: decodes write/read frames into register-bus
// strobes and streams read data back as four response bytes.
module regbus_cmd_master #(
  parameter int RD_TIMEOUT    = 15,
  parameter int FRAME_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wr_en,
  output logic [3:0]  be,
  output logic [15:0] wr_addr,
  output logic [31:0] wdata,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [31:0] rdata,
  input  logic        rd_rdy,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0]  OP_WR  = 8'h57;
  localparam logic [7:0]  OP_RD  = 8'h52;
  localparam logic [15:0] R_LAST = 16'(RD_TIMEOUT - 1);
  localparam logic [15:0] F_LAST = 16'(FRAME_TIMEOUT - 1);
  localparam logic [31:0] RD_BAD = 32'hDEADBEEF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_BE,
    S_DATA,
    S_WR_ISSUE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_TX
  } state_t;

  state_t      state_q, state_d;
  logic        is_rd_q, is_rd_d;
  logic [15:0] addr_q, addr_d;
  logic [3:0]  be_sh_q, be_sh_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [31:0] tx_sh_q, tx_sh_d;
  logic [1:0]  tcnt_q, tcnt_d;
  logic [7:0]  err_q, err_d;

  logic        rx_ready_q, rx_ready_d;
  logic        busy_q, busy_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic        tx_valid_q, tx_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic rx_acc;
  logic tx_acc;
  logic in_frame;
  logic f_abort;
  logic err_inc;

  assign rx_acc   = rx_valid & rx_ready_q;
  assign tx_acc   = tx_valid_q & tx_ready;
  assign in_frame = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) ||
                    (state_q == S_BE) || (state_q == S_DATA);

  always_comb begin
    state_d = state_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    be_sh_d = be_sh_q;
    data_d  = data_q;
    dcnt_d  = dcnt_q;
    fcnt_d  = fcnt_q;
    wcnt_d  = wcnt_q;
    tx_sh_d = tx_sh_q;
    tcnt_d  = tcnt_q;
    f_abort = 1'b0;
    err_inc = 1'b0;

    // Inter-byte idle timer, restarted by every accepted frame byte
    if (in_frame) begin
      if (rx_acc) begin
        fcnt_d = '0;
      end else if (fcnt_q == F_LAST) begin
        f_abort = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 16'd1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (rx_acc) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            state_d = S_ADDR_HI;
            is_rd_d = (rx_data == OP_RD);
            fcnt_d  = '0;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      S_ADDR_HI: begin
        if (rx_acc) begin
          addr_d[15:8] = rx_data;
          state_d      = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (rx_acc) begin
          addr_d[7:0] = rx_data;
          state_d     = is_rd_q ? S_RD_ISSUE : S_BE;
        end
      end
      S_BE: begin
        if (rx_acc) begin
          be_sh_d = rx_data[3:0];
          dcnt_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_acc) begin
          data_d = {data_q[23:0], rx_data};
          dcnt_d = dcnt_q + 2'd1;
          if (dcnt_q == 2'd3) state_d = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        state_d = S_IDLE;
      end
      S_RD_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rd_rdy) begin
          tx_sh_d = rdata;
          tcnt_d  = '0;
          state_d = S_TX;
        end else if (wcnt_q == R_LAST) begin
          tx_sh_d = RD_BAD;
          tcnt_d  = '0;
          err_inc = 1'b1;
          state_d = S_TX;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      S_TX: begin
        if (tx_acc) begin
          tx_sh_d = {tx_sh_q[23:0], 8'h00};
          tcnt_d  = tcnt_q + 2'd1;
          if (tcnt_q == 2'd3) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (f_abort) begin
      state_d = S_IDLE;
      err_inc = 1'b1;
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    // Outputs are registered copies of the decode of the next state
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR_HI) ||
                 (state_d == S_ADDR_LO) || (state_d == S_BE) ||
                 (state_d == S_DATA);
    busy_d     = (state_d != S_IDLE);
    wr_en_d    = (state_d == S_WR_ISSUE);
    rd_en_d    = (state_d == S_RD_ISSUE);
    tx_valid_d = (state_d == S_TX);

    wr_addr_d = wr_addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rd_addr_d = rd_addr_q;
    if (wr_en_d) begin
      wr_addr_d = addr_d;
      be_d      = be_sh_d;
      wdata_d   = data_d;
    end
    if (rd_en_d) begin
      rd_addr_d = addr_d;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_IDLE;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      be_sh_q    <= '0;
      data_q     <= '0;
      dcnt_q     <= '0;
      fcnt_q     <= '0;
      wcnt_q     <= '0;
      tx_sh_q    <= '0;
      tcnt_q     <= '0;
      err_q      <= '0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      be_sh_q    <= be_sh_d;
      data_q     <= data_d;
      dcnt_q     <= dcnt_d;
      fcnt_q     <= fcnt_d;
      wcnt_q     <= wcnt_d;
      tx_sh_q    <= tx_sh_d;
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      tx_valid_q <= tx_valid_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign tx_data  = tx_sh_q[31:24];
  assign tx_valid = tx_valid_q;
  assign wr_en    = wr_en_q;
  assign be       = be_q;
  assign wr_addr  = wr_addr_q;
  assign wdata    = wdata_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign busy     = busy_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_regbus_cmd_master.sv
// Directed bench for regbus_cmd_master: write, read, backpressure,
// read timeout, bad opcode, frame timeout and reset during a read.
module tb_regbus_cmd_master;

  logic        clk = 1'b0;
  logic        rstb;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wr_en;
  logic [3:0]  be;
  logic [15:0] wr_addr;
  logic [31:0] wdata;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [31:0] rdata;
  logic        rd_rdy;
  logic        busy;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  regbus_cmd_master #(
    .RD_TIMEOUT(15),
    .FRAME_TIMEOUT(32)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .wr_en(wr_en),
    .be(be),
    .wr_addr(wr_addr),
    .wdata(wdata),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rdata(rdata),
    .rd_rdy(rd_rdy),
    .busy(busy),
    .err_cnt(err_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          wr_cnt  = 0;
  int          rd_cnt  = 0;
  int          both_hi = 0;
  int          rd_cyc  = 0;
  int          tx_cyc  = 0;
  logic [15:0] m_wr_addr = '0;
  logic [15:0] m_rd_addr = '0;
  logic [3:0]  m_be      = '0;
  logic [31:0] m_wdata   = '0;
  logic [7:0]  txq[$];
  logic        txv_prev  = 1'b0;
  logic        resp_en   = 1'b0;
  logic        resp_pend = 1'b0;
  logic [31:0] resp_data = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      m_wr_addr = wr_addr;
      m_be      = be;
      m_wdata   = wdata;
    end
    if (rd_en) begin
      rd_cnt++;
      m_rd_addr = rd_addr;
      rd_cyc    = cyc;
      if (resp_en) resp_pend = 1'b1;
    end
    if (wr_en && rd_en) both_hi++;
    if (tx_valid && !txv_prev) tx_cyc = cyc;
    txv_prev = tx_valid;
    if (tx_valid && tx_ready) txq.push_back(tx_data);
  end

  // Read responder: rd_rdy for one cycle, the cycle after rd_en
  always @(posedge clk) begin
    #1;
    rd_rdy    = resp_pend;
    rdata     = resp_pend ? resp_data : 32'h0;
    resp_pend = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    logic ok;
    ok       = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (rx_ready) ok = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    if (!ok) chk("rx_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 200 && txq.size() < n; i++) tick();
  endtask

  function automatic logic [31:0] tx_word();
    logic [31:0] w;
    w = 32'hxxxxxxxx;
    if (txq.size() >= 4) w = {txq[0], txq[1], txq[2], txq[3]};
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int wr_base;
  int rd_base;

  initial begin
    rstb     = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    rd_rdy   = 1'b0;
    rdata    = '0;
    repeat (3) tick();

    // reset state
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_strobes", {30'd0, wr_en, rd_en}, 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rstb = 1'b1;
    @(negedge clk);
    chk("rel_rx_ready0", 32'(rx_ready), 32'd0);
    tick();
    chk("rel_rx_ready1", 32'(rx_ready), 32'd1);

    // write frame
    send(8'h57); send(8'h00); send(8'h0C); send(8'h0F);
    send(8'h12); send(8'h34); send(8'h5A); send(8'hBC);
    repeat (3) tick();
    chk("wr_cnt", 32'(wr_cnt), 32'd1);
    chk("wr_addr", 32'(m_wr_addr), 32'h000C);
    chk("wr_be", 32'(m_be), 32'hF);
    chk("wr_data", m_wdata, 32'h12345ABC);
    chk("wr_busy", 32'(busy), 32'd0);
    chk("wr_hold", wdata, 32'h12345ABC);
    chk("wr_no_rd", 32'(rd_cnt), 32'd0);

    // read with responder
    resp_en   = 1'b1;
    resp_data = 32'hCAFEF00D;
    txq.delete();
    send(8'h52); send(8'h00); send(8'h04);
    wait_tx(4);
    repeat (4) tick();
    chk("rd_cnt", 32'(rd_cnt), 32'd1);
    chk("rd_addr", 32'(m_rd_addr), 32'h0004);
    chk("rd_lat", 32'(tx_cyc - rd_cyc), 32'd2);
    chk("rd_nbytes", 32'(txq.size()), 32'd4);
    chk("rd_bytes", tx_word(), 32'hCAFEF00D);
    chk("rd_busy", 32'(busy), 32'd0);

    // backpressure during the second response byte
    txq.delete();
    send(8'h52); send(8'h00); send(8'h10);
    wait_tx(1);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {23'd0, tx_valid, tx_data}, 32'h1FE);
      tick();
    end
    tx_ready = 1'b1;
    wait_tx(4);
    repeat (6) tick();
    chk("bp_nbytes", 32'(txq.size()), 32'd4);
    chk("bp_bytes", tx_word(), 32'hCAFEF00D);
    chk("bp_rd_addr", 32'(m_rd_addr), 32'h0010);

    // read timeout
    resp_en = 1'b0;
    txq.delete();
    send(8'h52); send(8'h00); send(8'h20);
    wait_tx(4);
    repeat (3) tick();
    chk("to_lat", 32'(tx_cyc - rd_cyc), 32'd16);
    chk("to_bytes", tx_word(), 32'hDEADBEEF);
    chk("to_err", 32'(err_cnt), 32'd1);

    // bad opcode then write with upper BE bits set
    wr_base = wr_cnt;
    rd_base = rd_cnt;
    send(8'h41);
    repeat (2) tick();
    chk("bad_err", 32'(err_cnt), 32'd2);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_strobe", 32'(wr_cnt + rd_cnt), 32'(wr_base + rd_base));
    send(8'h57); send(8'h12); send(8'h34); send(8'hA5);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    repeat (3) tick();
    chk("bw_cnt", 32'(wr_cnt), 32'(wr_base + 1));
    chk("bw_addr", 32'(m_wr_addr), 32'h1234);
    chk("bw_be", 32'(m_be), 32'h5);
    chk("bw_data", m_wdata, 32'hDEADBEEF);

    // frame timeout after two bytes
    wr_base = wr_cnt;
    send(8'h57); send(8'h00);
    repeat (31) tick();
    chk("ft_busy31", 32'(busy), 32'd1);
    tick();
    chk("ft_busy32", 32'(busy), 32'd0);
    chk("ft_err", 32'(err_cnt), 32'd3);
    repeat (3) tick();
    chk("ft_no_wr", 32'(wr_cnt), 32'(wr_base));
    chk("ft_rx_ready", 32'(rx_ready), 32'd1);

    // reset while waiting for read data
    txq.delete();
    send(8'h52); send(8'h00); send(8'h08);
    repeat (4) tick();
    rd_base = rd_cnt;
    wr_base = wr_cnt;
    chk("rr_busy", 32'(busy), 32'd1);
    rstb = 1'b0;
    #1;
    chk("rr_outs", {tx_valid, busy, rx_ready, wr_en, rd_en, 27'd0}, 32'd0);
    chk("rr_regs", 32'(wr_addr) | 32'(rd_addr) | 32'(be) | 32'(err_cnt), 32'd0);
    chk("rr_wdata", wdata, 32'd0);
    tick();
    rstb = 1'b1;
    repeat (30) tick();
    chk("rr_no_tx", 32'(txq.size()), 32'd0);
    chk("rr_no_strobe", 32'(rd_cnt + wr_cnt), 32'(rd_base + wr_base));
    chk("rr_idle", {30'd0, busy, tx_valid}, 32'd0);
    chk("rr_err", 32'(err_cnt), 32'd0);
    chk("both_hi", 32'(both_hi), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
